joybus_poll_ctrl: RTL and testbench

JOYBUS_POLL_CTRL -- requirements
Module: joybus_poll_ctrl

---
 rtl/joybus_poll_if.sv | 28 ++
 rtl/joybus_poll_ctrl.sv | 110 +++++++++++
 tb/tb_joybus_poll_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/joybus_poll_if.sv
// Signal bundle between the Joybus poll controller and its transmitter, receiver and host.
// The master modport is the controller side. The slave modport is the peripheral side.
interface joybus_poll_if;
  logic        poll_en;
  logic        cmd_rdy;
  logic [7:0]  cmd_data;
  logic        tx_done;
  logic [7:0]  rx_byte;
  logic        rx_byte_vld;
  logic        rx_done;
  logic [31:0] status;
  logic        status_vld;
  logic        btn_A;
  logic        btn_B;
  logic        btn_Z;
  logic        btn_start;
  logic        err;

  modport master (
    input  poll_en, tx_done, rx_byte, rx_byte_vld, rx_done,
    output cmd_rdy, cmd_data, status, status_vld, btn_A, btn_B, btn_Z, btn_start, err
  );

  modport slave (
    output poll_en, tx_done, rx_byte, rx_byte_vld, rx_done,
    input  cmd_rdy, cmd_data, status, status_vld, btn_A, btn_B, btn_Z, btn_start, err
  );
endinterface

// File: rtl/joybus_poll_ctrl.sv
// Periodic Joybus controller poller. It sends POLL_CMD, collects the 4-byte reply and
// publishes it as status. A timeout or a wrong byte count raises a sticky err flag.
module joybus_poll_ctrl #(
  parameter int unsigned POLL_PERIOD = 833333,
  parameter int unsigned RX_TIMEOUT  = 50000,
  parameter logic [7:0]  POLL_CMD    = 8'h01
) (
  input logic          clk,
  input logic          rst,
  joybus_poll_if.master bus
);

  localparam int unsigned PW = $clog2(POLL_PERIOD + 1);
  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
  localparam logic [PW-1:0] PeriodLast = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TmoLast    = TW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWait, StSend, StWaitTx, StRecv, StCheck} state_e;

  state_e        state_q;
  logic [PW-1:0] period_q;
  logic [TW-1:0] tmo_q;
  logic [2:0]    byte_cnt_q;
  logic [31:0]   shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      period_q       <= '0;
      tmo_q          <= '0;
      byte_cnt_q     <= '0;
      shift_q        <= '0;
      bus.cmd_rdy    <= 1'b0;
      bus.status     <= '0;
      bus.status_vld <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.cmd_rdy    <= 1'b0;
      bus.status_vld <= 1'b0;
      // Free-running poll timer. A later clear in the case below takes priority.
      if (state_q != StIdle && period_q != PeriodLast) begin
        period_q <= period_q + PW'(1);
      end
      case (state_q)
        StIdle: begin
          if (bus.poll_en) begin
            state_q  <= StSend;
            period_q <= '0;
          end
        end
        StSend: begin
          bus.cmd_rdy <= 1'b1;
          state_q     <= StWaitTx;
        end
        StWaitTx: begin
          if (bus.tx_done) begin
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            state_q    <= StRecv;
          end
        end
        StRecv: begin
          if (bus.rx_byte_vld) begin
            shift_q <= {shift_q[23:0], bus.rx_byte};
            if (byte_cnt_q != 3'd5) begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
          // rx_done on the final timeout cycle still counts as a completed frame.
          if (bus.rx_done) begin
            state_q <= StCheck;
          end else if (tmo_q == TmoLast) begin
            bus.err <= 1'b1;
            state_q <= StWait;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StCheck: begin
          if (byte_cnt_q == 3'd4) begin
            bus.status     <= shift_q;
            bus.status_vld <= 1'b1;
            bus.err        <= 1'b0;
          end else begin
            bus.err <= 1'b1;
          end
          state_q <= StWait;
        end
        StWait: begin
          if (period_q == PeriodLast) begin
            if (bus.poll_en) begin
              state_q  <= StSend;
              period_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_data  = POLL_CMD;
  assign bus.btn_A     = bus.status[31];
  assign bus.btn_B     = bus.status[30];
  assign bus.btn_Z     = bus.status[29];
  assign bus.btn_start = bus.status[28];

endmodule

// File: tb/tb_joybus_poll_ctrl.sv
// Self-checking bench for joybus_poll_ctrl. Random controller replies are compared against
// a frame-level reference model of status, err, status_vld and poll timing.
module tb_joybus_poll_ctrl;
  localparam int unsigned P  = 100;
  localparam int unsigned RT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  joybus_poll_if bus ();

  joybus_poll_ctrl #(
    .POLL_PERIOD(P),
    .RX_TIMEOUT (RT),
    .POLL_CMD   (8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int last_cmd = 0;
  logic [31:0] exp_status = '0;
  logic        exp_err = 1'b0;
  logic [7:0]  fb [0:7];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.status_vld === 1'b1) vld_cnt <= vld_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Reference model: a frame is good only when exactly four bytes arrived.
  function automatic int model_frame(input int n);
    if (n == 4) begin
      exp_status = {fb[0], fb[1], fb[2], fb[3]};
      exp_err    = 1'b0;
      return 1;
    end
    exp_err = 1'b1;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
  endtask

  task automatic wait_cmd(output int at);
    at = -1;
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL cmd_rdy_wait: no cmd_rdy within %0d cycles, expected a poll", 3 * P);
    end
  endtask

  // Called at the negedge where cmd_rdy is seen. Returns the cycle in which rx_done was sampled.
  task automatic run_frame(input int n, input bit same_cycle, output int rdone);
    tick($urandom_range(0, 3));
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      bus.rx_byte     = fb[i];
      bus.rx_byte_vld = 1'b1;
      if (same_cycle && i == n - 1) bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_byte_vld = 1'b0;
      bus.rx_done     = 1'b0;
    end
    if (!same_cycle || n == 0) begin
      tick($urandom_range(0, 2));
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
    end
    rdone = cyc;
  endtask

  task automatic check_frame(input string name, input int vld_delta, input int exp_vld);
    checks++;
    if (bus.status !== exp_status) begin
      errors++;
      $display("FAIL %s_status: got %h expected %h", name, bus.status, exp_status);
    end
    checks++;
    if (bus.err !== exp_err) begin
      errors++;
      $display("FAIL %s_err: got %b expected %b", name, bus.err, exp_err);
    end
    checks++;
    if (vld_delta != exp_vld) begin
      errors++;
      $display("FAIL %s_vld: got %0d pulses expected %0d", name, vld_delta, exp_vld);
    end
    checks++;
    if ({bus.btn_A, bus.btn_B, bus.btn_Z, bus.btn_start} !== exp_status[31:28]) begin
      errors++;
      $display("FAIL %s_btn: got %b expected %b", name,
               {bus.btn_A, bus.btn_B, bus.btn_Z, bus.btn_start}, exp_status[31:28]);
    end
  endtask

  task automatic check_gap(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d cycles expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.status_vld !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got cmd_rdy=%b status_vld=%b err=%b expected 0 0 0",
               bus.cmd_rdy, bus.status_vld, bus.err);
    end
    checks++;
    if (bus.cmd_data !== 8'h01) begin
      errors++;
      $display("FAIL reset_cmd_data: got %h expected 01", bus.cmd_data);
    end
    checks++;
    if (bus.status !== 32'h0 || bus.btn_A !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %h expected 00000000", bus.status);
    end
  endtask

  // poll_en is set at negedge c0: SEND in cycle c0+1, cmd_rdy visible in cycle c0+2.
  task automatic first_poll(input string name);
    bus.poll_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: got cmd_rdy=%b expected 0", name, bus.cmd_rdy);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd_data !== 8'h01) begin
      errors++;
      $display("FAIL %s_cmd: got cmd_rdy=%b data=%h expected 1 01", name, bus.cmd_rdy,
               bus.cmd_data);
    end
    last_cmd = cyc;
  endtask

  task automatic test_first_poll();
    int v0, r, ev;
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    first_poll("first_poll");
    fb[0] = 8'h80; fb[1] = 8'h00; fb[2] = 8'h05; fb[3] = 8'hFB;
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    tick(3);
    check_frame("known_frame", vld_cnt - v0, ev);
    checks++;
    if (bus.status !== 32'h800005FB || bus.btn_A !== 1'b1 || bus.btn_B !== 1'b0) begin
      errors++;
      $display("FAIL known_frame_value: got %h A=%b B=%b expected 800005fb A=1 B=0",
               bus.status, bus.btn_A, bus.btn_B);
    end
  endtask

  task automatic test_back_to_back();
    int at, v0, r, ev;
    for (int it = 0; it < 4; it++) begin
      randomize_bytes();
      wait_cmd(at);
      check_gap("b2b_period", at - last_cmd, P);
      checks++;
      if (bus.cmd_data !== 8'h01) begin
        errors++;
        $display("FAIL b2b_cmd_data: got %h expected 01", bus.cmd_data);
      end
      last_cmd = at;
      v0 = vld_cnt;
      run_frame(4, (it == 1) ? 1'b1 : 1'($urandom_range(0, 1)), r);
      ev = model_frame(4);
      tick(3);
      check_frame("b2b", vld_cnt - v0, ev);
    end
  endtask

  task automatic test_bad_count();
    int at, v0, r, ev;
    int lens [4] = '{3, 0, 5, 4};
    for (int it = 0; it < 4; it++) begin
      randomize_bytes();
      wait_cmd(at);
      check_gap("bad_period", at - last_cmd, P);
      last_cmd = at;
      v0 = vld_cnt;
      run_frame(lens[it], 1'($urandom_range(0, 1)), r);
      ev = model_frame(lens[it]);
      tick(3);
      check_frame($sformatf("count%0d", lens[it]), vld_cnt - v0, ev);
    end
  endtask

  task automatic test_ignore();
    int at, v0, r, ev;
    v0 = vld_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.rx_byte = 8'($urandom);
      bus.rx_byte_vld = 1'b1;
      bus.tx_done = (i == 2);
      @(negedge clk);
    end
    bus.rx_byte_vld = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    tick(3);
    check_frame("ignore", vld_cnt - v0, 0);
    randomize_bytes();
    wait_cmd(at);
    check_gap("ignore_period", at - last_cmd, P);
    last_cmd = at;
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    tick(3);
    check_frame("ignore_next", vld_cnt - v0, ev);
  endtask

  task automatic test_timeout();
    int at, v0, r, ev;
    wait_cmd(at);
    check_gap("tmo_period", at - last_cmd, P);
    last_cmd = at;
    v0 = vld_cnt;
    tick(1);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    tick(19);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got err=%b 19 cycles after tx_done expected 0", bus.err);
    end
    tick(1);
    exp_err = 1'b1;
    check_frame("tmo", vld_cnt - v0, 0);
    wait_cmd(at);
    check_gap("tmo_next_period", at - last_cmd, P);
    last_cmd = at;
    randomize_bytes();
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    tick(3);
    check_frame("tmo_recover", vld_cnt - v0, ev);
  endtask

  // rx_done sampled in cycle R: CHECK, WAIT, SEND follow, so cmd_rdy is seen in cycle R+3.
  task automatic test_overrun();
    int at, v0, r, ev;
    wait_cmd(at);
    check_gap("ovr_period", at - last_cmd, P);
    randomize_bytes();
    tick(P + 20);
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    wait_cmd(at);
    check_gap("ovr_resend", at - r, 3);
    check_frame("ovr", vld_cnt - v0, ev);
    last_cmd = at;
    randomize_bytes();
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    wait_cmd(at);
    check_gap("ovr_after_period", at - last_cmd, P);
    last_cmd = at;
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    tick(3);
    check_frame("ovr_after", vld_cnt - v0, ev);
  endtask

  task automatic test_poll_disable();
    int at, v0, r, ev, seen;
    wait_cmd(at);
    check_gap("dis_period", at - last_cmd, P);
    bus.poll_en = 1'b0;
    randomize_bytes();
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    tick(3);
    check_frame("dis_complete", vld_cnt - v0, ev);
    seen = 0;
    for (int k = 0; k < 2 * P; k++) begin
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1) seen++;
    end
    check_gap("dis_no_poll", seen, 0);
    first_poll("repoll");
    randomize_bytes();
    v0 = vld_cnt;
    run_frame(4, 1'b0, r);
    ev = model_frame(4);
    tick(3);
    check_frame("repoll", vld_cnt - v0, ev);
  endtask

  task automatic test_reset_mid_recv();
    int at, v0, r, ev;
    randomize_bytes();
    wait_cmd(at);
    last_cmd = at;
    run_frame(3, 1'b0, r);
    ev = model_frame(3);
    wait_cmd(at);
    tick(1);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.rx_byte = fb[i];
      bus.rx_byte_vld = 1'b1;
      @(negedge clk);
    end
    bus.rx_byte_vld = 1'b0;
    bus.poll_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_status = '0;
    exp_err = 1'b0;
    check_frame("async_rst", 0, 0);
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.status_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_pulses: got cmd_rdy=%b status_vld=%b expected 0 0",
               bus.cmd_rdy, bus.status_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    v0 = vld_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.rx_byte = fb[i];
      bus.rx_byte_vld = 1'b1;
      bus.rx_done = (i == 3);
      @(negedge clk);
    end
    bus.rx_byte_vld = 1'b0;
    bus.rx_done = 1'b0;
    tick(4);
    check_frame("post_rst_idle", vld_cnt - v0, 0);
    first_poll("post_rst_poll");
    randomize_bytes();
    v0 = vld_cnt;
    run_frame(4, 1'b1, r);
    ev = model_frame(4);
    tick(3);
    check_frame("post_rst_frame", vld_cnt - v0, ev);
  endtask

  initial begin
    bus.poll_en     = 1'b0;
    bus.tx_done     = 1'b0;
    bus.rx_byte     = 8'h00;
    bus.rx_byte_vld = 1'b0;
    bus.rx_done     = 1'b0;
    for (int i = 0; i < 8; i++) fb[i] = 8'h00;
    test_reset();
    test_first_poll();
    test_back_to_back();
    test_bad_count();
    test_ignore();
    test_timeout();
    test_overrun();
    test_poll_disable();
    test_reset_mid_recv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
